srff_sync_driver: RTL and testbench
===================================

# srff_sync_driver

Command-driven stimulus generator and checker for a synchronous SR flip-flop: it accepts SET/RESET/TOGGLE/NOP commands over a valid/ready handshake and converts them into legal `s`/`r` pulses with programmable width and gap. It never drives `s` and `r` high together. It tracks the expected flop output and compares it against the flop's `q` fed back, flagging mismatches. It sits on the drive side of the SR flop, sharing its clock and synchronous reset.

## Interface
Parameters:
- `PULSE_W`, 1: cycles `s` or `r` is held high per command; legal range ≥1.
- `GAP_W`, 1: cycles `s=r=0` after each pulse before the next command is accepted; legal range ≥1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_sync`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_op`  in  2  opcode: 00 NOP, 01 SET, 10 RESET, 11 TOGGLE.
- `cmd_ready`  out  1  block can accept a command.
- `s`  out  1  set drive to the SR flop, registered.
- `r`  out  1  reset drive to the SR flop, registered.
- `q_fb`  in  1  SR flop `q`, fed back.
- `q_exp`  out  1  expected flop state.
- `busy`  out  1  high in PULSE or GAP.
- `err`  out  1  sticky mismatch flag.
- `err_clr`  in  1  clears `err`.
- `err_cnt`  out  8  saturating mismatch count.

## Operation
- The FSM has three states: IDLE, PULSE, GAP.
- `cmd_ready` = (state==IDLE). `busy` = ~`cmd_ready`.
- Accept = `cmd_valid & cmd_ready` at a rising edge with `rst_sync=0`.
- Accepting NOP: the FSM stays in IDLE and nothing else changes.
- Accepting SET, RESET or TOGGLE:
  - Latch the target: SET→1, RESET→0, TOGGLE→~`q_exp` as sampled at the accept edge.
  - Load the counter with PULSE_W−1 and go to PULSE.
- PULSE state:
  - Target 1 drives `s=1, r=0`; target 0 drives `s=0, r=1`.
  - A pulse is issued even when the target equals `q_exp`, so a redundant SET still pulses `s`.
  - When the counter reaches 0, go to GAP with counter = GAP_W−1 and `s=r=0`, and load `q_exp` ← target on that edge.
- GAP state: `s=r=0`. When the counter reaches 0, go to IDLE.
- Invariant: `s&r` is never 1 in any cycle. Bench assertion.
- Checking:
  - Compare `q_fb` with `q_exp` in every IDLE and GAP cycle. No compare in PULSE, where the flop is in transition.
  - A mismatch sets `err` at the next edge and increments `err_cnt`; the count saturates at 255.
  - If `err_clr` and a mismatch occur in the same cycle, set wins and `err`=1.
  - `err_clr` does not clear `err_cnt`; only reset does.
- Reset (`rst_sync`=1 at an edge, including mid-PULSE or mid-GAP):
  - state=IDLE, `s=0`, `r=0`, `q_exp=0`, `err=0`, `err_cnt=0`, counter=0.
  - Therefore `cmd_ready=1` and `busy=0` after the reset edge.
  - A command presented during a reset cycle is not accepted.

## Timing
- Accept at edge t:
  - `s`/`r` is high for cycles t+1 … t+PULSE_W.
  - `q_exp` changes at edge t+PULSE_W.
  - GAP covers cycles t+PULSE_W+1 … t+PULSE_W+GAP_W.
  - `cmd_ready` rises after edge t+PULSE_W+GAP_W.
- Command period is PULSE_W+GAP_W+1 cycles. A NOP costs 1 cycle.
- The flop samples the final pulse cycle at edge t+PULSE_W, so `q_fb` is valid in the first GAP cycle. The first compare occurs there.
- Error latency: a mismatch in cycle k gives `err` high from edge k+1.

## Test plan
Defaults PULSE_W=1, GAP_W=1 unless stated; the bench models a synchronous SR flop sharing `clk`/`rst_sync`.
- Reset, then SET accepted at edge 1 → `s=1` only in cycle 2; `q_exp`=1 from edge 2; `cmd_ready`=1 again from edge 3; `err`=0.
- SET, RESET, TOGGLE, TOGGLE back-to-back with `cmd_valid` held high → `q_exp` sequence 1,0,1,0; each command accepted every 3 cycles; `s&r` never 1.
- PULSE_W=3, GAP_W=2, RESET from `q_exp`=1 → `r` high for 3 cycles; `cmd_ready` low for 5 cycles; `q_exp`=0 at the third pulse edge.
- Flop model forced to `q`=0 after a SET → `err`=1 one cycle after the first GAP cycle; `err_cnt` increments each mismatching cycle; `err_clr` with the mismatch persisting → `err` stays 1; fixing `q` and then asserting `err_clr` → `err`=0 and `err_cnt` holds its value.
- Assert `rst_sync` in the middle of a PULSE with `s`=1 → after the edge `s=0`, `q_exp=0`, `cmd_ready=1`, and `err`=0/`err_cnt`=0; a `cmd_valid` held during reset is not accepted.
- NOP with `cmd_valid` high for 4 cycles → `cmd_ready` stays 1; `s`/`r`/`q_exp` unchanged; `err_cnt` saturation is checked by forcing more than 255 mismatching cycles, after which it holds at 255.

Source files
------------

// File: rtl/srff_sync_driver.sv
// Command-driven pulse generator for a synchronous SR flop, with expected-state
// tracking and a sticky/saturating mismatch checker on the fed-back q.
module srff_sync_driver #(
  parameter int unsigned PULSE_W = 1,
  parameter int unsigned GAP_W   = 1
) (
  input  logic       clk,
  input  logic       rst_sync,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       s,
  output logic       r,
  input  logic       q_fb,
  output logic       q_exp,
  output logic       busy,
  output logic       err,
  input  logic       err_clr,
  output logic [7:0] err_cnt
);

  localparam int unsigned CNT_MAX   = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned ERR_CNT_W = 8;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PULSE = 2'b01,
    GAP   = 2'b10
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   tgt_q, tgt_d;
  logic                   s_d, r_d, q_exp_d, ready_d;
  logic                   err_d;
  logic [ERR_CNT_W-1:0]   err_cnt_d;
  logic                   mismatch;

  // Next-state, pulse shaping and checker update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    q_exp_d   = q_exp;
    err_d     = err;
    err_cnt_d = err_cnt;
    mismatch  = (state_q != PULSE) && (q_fb != q_exp);

    // A mismatch beats a simultaneous clear
    if (mismatch) begin
      err_d = 1'b1;
      if (err_cnt != {ERR_CNT_W{1'b1}}) begin
        err_cnt_d = err_cnt + ERR_CNT_W'(1);
      end
    end else if (err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid && (cmd_op != OP_NOP)) begin
          state_d = PULSE;
          cnt_d   = CNT_W'(PULSE_W - 1);
          tgt_d   = (cmd_op == OP_TOGGLE) ? ~q_exp : (cmd_op == OP_SET);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = CNT_W'(GAP_W - 1);
          q_exp_d = tgt_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so s/r can never overlap
    s_d     = (state_d == PULSE) && tgt_d;
    r_d     = (state_d == PULSE) && !tgt_d;
    ready_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tgt_q     <= 1'b0;
      s         <= 1'b0;
      r         <= 1'b0;
      q_exp     <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      s         <= s_d;
      r         <= r_d;
      q_exp     <= q_exp_d;
      err       <= err_d;
      err_cnt   <= err_cnt_d;
      cmd_ready <= ready_d;
      busy      <= ~ready_d;
    end
  end

endmodule

// File: tb/tb_srff_sync_driver.sv
// Two driver instances (1/1 and 3/2 pulse/gap) share stimulus; each drives its
// own synchronous SR flop model and is scored cycle by cycle against a reference.
module tb_srff_sync_driver;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] SET = 2'b01;
  localparam logic [1:0] RST = 2'b10;
  localparam logic [1:0] TOG = 2'b11;

  typedef struct packed {
    logic       rdy;
    logic       busy;
    logic       s;
    logic       r;
    logic       qe;
    logic       err;
    logic [7:0] cnt;
  } obs_t;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       err_clr;

  logic       rdy    [2];
  logic       busy   [2];
  logic       s      [2];
  logic       r      [2];
  logic       qe     [2];
  logic       err    [2];
  logic [7:0] cnt    [2];
  logic       qf     [2];
  logic       q_fb   [2];
  logic       force0 [2];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input int g, input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL dut%0d %s got=%0d exp=%0d t=%0t", g, name, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int PW = (g == 0) ? 1 : 3;
    localparam int GW = (g == 0) ? 1 : 2;

    obs_t sbq[$];

    srff_sync_driver #(.PULSE_W(PW), .GAP_W(GW)) u_dut (
      .clk       (clk),
      .rst_sync  (rst),
      .cmd_valid (cmd_valid),
      .cmd_op    (cmd_op),
      .cmd_ready (rdy[g]),
      .s         (s[g]),
      .r         (r[g]),
      .q_fb      (q_fb[g]),
      .q_exp     (qe[g]),
      .busy      (busy[g]),
      .err       (err[g]),
      .err_clr   (err_clr),
      .err_cnt   (cnt[g])
    );

    // Synchronous SR flop being driven; q can be forced low to inject errors
    always @(posedge clk) begin
      if (rst)       qf[g] <= 1'b0;
      else if (s[g]) qf[g] <= 1'b1;
      else if (r[g]) qf[g] <= 1'b0;
    end
    assign q_fb[g] = force0[g] ? 1'b0 : qf[g];

    // Reference: 'left' counts remaining cycles of the current command
    // (PW pulse cycles then GW gap cycles); zero means idle.
    initial begin : model
      int   left;
      int   ecnt;
      bit   tgt, eq, eerr, armed, mism;
      obs_t o;
      left = 0; ecnt = 0; tgt = 0; eq = 0; eerr = 0; armed = 0;
      forever begin
        @(posedge clk);
        if (rst) begin
          left = 0; eq = 0; eerr = 0; ecnt = 0; armed = 1;
        end else if (armed) begin
          mism = (left <= GW) && (q_fb[g] != eq);
          if (mism) begin
            eerr = 1;
            if (ecnt < 255) ecnt++;
          end else if (err_clr) begin
            eerr = 0;
          end
          if (left > 0) begin
            left--;
            if (left == GW) eq = tgt;
          end else if (cmd_valid && cmd_op != NOP) begin
            tgt  = (cmd_op == SET) ? 1'b1 : (cmd_op == RST) ? 1'b0 : !eq;
            left = PW + GW;
          end
        end
        if (armed) begin
          o.rdy  = (left == 0);
          o.busy = (left != 0);
          o.s    = (left > GW) && tgt;
          o.r    = (left > GW) && !tgt;
          o.qe   = eq;
          o.err  = eerr;
          o.cnt  = 8'(ecnt);
          sbq.push_back(o);
        end
      end
    end

    initial begin : monitor
      obs_t o;
      forever begin
        @(negedge clk);
        if (sbq.size() > 0) begin
          o = sbq.pop_front();
          check(g, "cmd_ready", int'(rdy[g]),  int'(o.rdy));
          check(g, "busy",      int'(busy[g]), int'(o.busy));
          check(g, "s",         int'(s[g]),    int'(o.s));
          check(g, "r",         int'(r[g]),    int'(o.r));
          check(g, "q_exp",     int'(qe[g]),   int'(o.qe));
          check(g, "err",       int'(err[g]),  int'(o.err));
          check(g, "err_cnt",   int'(cnt[g]),  int'(o.cnt));
          check(g, "s_and_r",   int'(s[g] & r[g]), 0);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for instance g to be ready, then present op for exactly one edge
  task automatic issue(input int g, input logic [1:0] op);
    int n;
    n = 0;
    while (!rdy[g] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[g]) check(g, "issue_timeout", 0, 1);
    cmd_op    = op;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(rdy[0] && rdy[1]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(rdy[0] && rdy[1])) check(0, "idle_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ops [4];
    int n;
    ops[0] = SET; ops[1] = RST; ops[2] = TOG; ops[3] = TOG;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; err_clr = 1'b0;
    force0[0] = 1'b0; force0[1] = 1'b0;
    step(3);
    for (int g = 0; g < 2; g++) begin
      check(g, "rst_ready", int'(rdy[g]), 1);
      check(g, "rst_busy",  int'(busy[g]), 0);
      check(g, "rst_q_exp", int'(qe[g]), 0);
      check(g, "rst_err_cnt", int'(cnt[g]), 0);
    end
    rst = 1'b0;

    // Single SET: one-cycle s pulse, q_exp follows at the pulse edge
    issue(0, SET);
    check(0, "set_s_high", int'(s[0]), 1);
    step(1);
    check(0, "set_s_low", int'(s[0]), 0);
    check(0, "set_q_exp", int'(qe[0]), 1);
    wait_idle();

    // Back-to-back SET, RESET, TOGGLE, TOGGLE with valid held high
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_op = ops[i];
      n = 0;
      while (!rdy[0] && n < 20) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    wait_idle();
    check(0, "b2b_final_q_exp", int'(qe[0]), 0);

    // Long pulse/gap instance: RESET from q_exp=1
    issue(1, SET);
    wait_idle();
    issue(1, RST);
    check(1, "reset_r_high", int'(r[1]), 1);
    wait_idle();

    // Forced q mismatch, clear while mismatching, then clear after fixing
    issue(0, SET);
    wait_idle();
    force0[0] = 1'b1; force0[1] = 1'b1;
    step(3);
    check(0, "err_set", int'(err[0]), 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check(0, "err_clr_lost", int'(err[0]), 1);
    force0[0] = 1'b0; force0[1] = 1'b0;
    step(1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check(0, "err_cleared", int'(err[0]), 0);
    check(1, "err_cleared", int'(err[1]), 0);

    // Reset in the middle of a pulse, with a command held across it
    issue(1, SET);
    check(1, "redundant_set_s", int'(s[1]), 1);
    cmd_valid = 1'b1; cmd_op = SET; rst = 1'b1;
    step(1);
    rst = 1'b0; cmd_valid = 1'b0;
    check(1, "midrst_s",     int'(s[1]),   0);
    check(1, "midrst_q_exp", int'(qe[1]),  0);
    check(1, "midrst_ready", int'(rdy[1]), 1);
    check(1, "midrst_err",   int'(err[1]), 0);
    check(1, "midrst_cnt",   int'(cnt[1]), 0);
    step(1);
    check(1, "midrst_no_accept", int'(rdy[1]), 1);

    // NOP held for four cycles
    cmd_valid = 1'b1; cmd_op = NOP;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check(0, "nop_ready", int'(rdy[0]), 1);
    end
    cmd_valid = 1'b0;

    // Saturation of err_cnt
    issue(0, SET);
    wait_idle();
    force0[0] = 1'b1; force0[1] = 1'b1;
    step(270);
    check(0, "sat_cnt", int'(cnt[0]), 255);
    check(1, "sat_cnt", int'(cnt[1]), 255);
    force0[0] = 1'b0; force0[1] = 1'b0;
    step(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom_range(0, 3));
      err_clr   = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 255) == 0);
      if ($urandom_range(0, 31) == 0) force0[0] = !force0[0];
      if ($urandom_range(0, 31) == 0) force0[1] = !force0[1];
      step(1);
    end
    rst = 1'b0; cmd_valid = 1'b0; err_clr = 1'b0;
    force0[0] = 1'b0; force0[1] = 1'b0;
    step(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
